// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
// Watches an incoming active-high hsync/vsync pair with 800x525 timing and
// rebuilds hcount/vcount/de from it. A SEARCH/LINE/FRAME/LOCKED state machine
// qualifies the stream. Timing violations seen while locked raise a one-cycle
// err pulse and bump a saturating error counter.
module vga_sync_decoder #(
    parameter int H_TOTAL      = 800,
    parameter int V_TOTAL      = 525,
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int H_SYNC_START = 656,
    parameter int H_SYNC_LEN   = 96,
    parameter int V_SYNC_START = 490,
    parameter int V_SYNC_LEN   = 2,
    parameter int LOCK_FRAMES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       de,
    output logic       locked,
    output logic       frame_start,
    output logic       err,
    output logic [7:0] err_count
);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_LINE   = 2'd1;
    localparam logic [1:0] ST_FRAME  = 2'd2;
    localparam logic [1:0] ST_LOCKED = 2'd3;

    localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT       = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT       = 10'(V_ACTIVE);
    localparam logic [9:0] H_SS        = 10'(H_SYNC_START);
    localparam logic [9:0] H_SE        = 10'(H_SYNC_START + H_SYNC_LEN);
    localparam logic [9:0] V_SS        = 10'(V_SYNC_START);
    localparam logic [9:0] V_SE        = 10'(V_SYNC_START + V_SYNC_LEN);
    localparam logic [7:0] GOOD_TARGET = 8'(LOCK_FRAMES);

    logic [1:0] state;
    logic [1:0] state_n;
    logic [7:0] good;
    logic [7:0] good_n;
    logic       hs_prev;
    logic       vs_prev;
    logic       hs_rise;
    logic       hs_fall;
    logic       vs_rise;
    logic       vs_fall;
    logic [9:0] p_h;
    logic [9:0] p_v;
    logic [9:0] hcount_n;
    logic [9:0] vcount_n;
    logic       h_bad;
    logic       v_at_sync;
    logic       v_at_end;
    logic       viol;
    logic       to_search;
    logic [7:0] err_count_n;

    // Edge detection against the previous sample, and the predicted position
    // of the sample being presented now (one pixel after the last reported one).
    always_comb begin
        hs_rise   = hsync_in & ~hs_prev;
        hs_fall   = ~hsync_in & hs_prev;
        vs_rise   = vsync_in & ~vs_prev;
        vs_fall   = ~vsync_in & vs_prev;
        p_h       = (hcount == H_LAST) ? 10'd0 : hcount + 10'd1;
        p_v       = vcount;
        if (p_h == 10'd0) begin
            p_v = (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
        end
        h_bad     = (hs_rise != (p_h == H_SS)) || (hs_fall && (p_h != H_SE));
        v_at_sync = (p_h == 10'd0) && (p_v == V_SS);
        v_at_end  = (p_h == 10'd0) && (p_v == V_SE);
    end

    // Lock state machine: decides the next state and the next counter values.
    always_comb begin
        state_n   = state;
        hcount_n  = hcount;
        vcount_n  = vcount;
        good_n    = good;
        viol      = 1'b0;
        to_search = 1'b0;
        case (state)
            ST_SEARCH: begin
                hcount_n = 10'd0;
                vcount_n = 10'd0;
                good_n   = 8'd0;
                if (hs_rise) begin
                    hcount_n = H_SS;
                    state_n  = ST_LINE;
                end
            end
            ST_LINE: begin
                if (h_bad) begin
                    to_search = 1'b1;
                end else begin
                    hcount_n = p_h;
                    vcount_n = 10'd0;
                    if (hs_rise) begin
                        state_n = ST_FRAME;
                    end
                end
            end
            ST_FRAME: begin
                if (h_bad) begin
                    to_search = 1'b1;
                end else if (vs_rise) begin
                    if ((p_h == 10'd0) && ((good == 8'd0) || (p_v == V_SS))) begin
                        hcount_n = p_h;
                        vcount_n = V_SS;
                        good_n   = good + 8'd1;
                        if (good_n == GOOD_TARGET) begin
                            state_n = ST_LOCKED;
                        end
                    end else begin
                        to_search = 1'b1;
                    end
                end else begin
                    hcount_n = p_h;
                    vcount_n = (good == 8'd0) ? 10'd0 : p_v;
                end
            end
            default: begin
                viol = h_bad
                    || (vs_rise && !v_at_sync)
                    || (vs_fall && !v_at_end)
                    || (v_at_sync && !vs_rise);
                if (viol) begin
                    to_search = 1'b1;
                end else begin
                    hcount_n = p_h;
                    vcount_n = p_v;
                end
            end
        endcase
        if (to_search) begin
            state_n  = ST_SEARCH;
            hcount_n = 10'd0;
            vcount_n = 10'd0;
            good_n   = 8'd0;
        end
        err_count_n = err_count;
        if (viol && (err_count != 8'hFF)) begin
            err_count_n = err_count + 8'd1;
        end
    end

    // Register state, counters and all outputs; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_SEARCH;
            good        <= 8'd0;
            hs_prev     <= 1'b0;
            vs_prev     <= 1'b0;
            hcount      <= 10'd0;
            vcount      <= 10'd0;
            de          <= 1'b0;
            locked      <= 1'b0;
            frame_start <= 1'b0;
            err         <= 1'b0;
            err_count   <= 8'd0;
        end else begin
            state       <= state_n;
            good        <= good_n;
            hs_prev     <= hsync_in;
            vs_prev     <= vsync_in;
            hcount      <= hcount_n;
            vcount      <= vcount_n;
            de          <= (state_n == ST_LOCKED) && (hcount_n < H_ACT) && (vcount_n < V_ACT);
            locked      <= (state_n == ST_LOCKED);
            frame_start <= (state_n == ST_LOCKED) && (hcount_n == 10'd0) && (vcount_n == 10'd0);
            err         <= viol;
            err_count   <= err_count_n;
        end
    end

endmodule
